// File: rtl/decim_sample_readout_if.sv
// AXI4-Lite register bus used by the decimated-sample readout block.
// The master modport is the PS side and the slave modport is the register file.
interface decim_sample_readout_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/decim_sample_readout.sv
// Captures decimated samples into a FIFO and exposes control, status, data-pop and
// threshold registers over AXI4-Lite, with a level-threshold interrupt.
module decim_sample_readout #(
   parameter int SAMPLE_WIDTH         = 24,
   parameter int FIFO_DEPTH           = 64,
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   input  logic [SAMPLE_WIDTH-1:0] sample_tdata,
   input  logic                    sample_tvalid,
   output logic                    irq,
   decim_sample_readout_if.slave   s00_axi
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int A_MSB = C_S00_AXI_ADDR_WIDTH - 1;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_STATUS = 2'd1,
      REG_DATA   = 2'd2,
      REG_THRESH = 2'd3
   } reg_addr_e;

   logic                    clk;
   logic                    rst_n;
   assign clk   = s00_axi_aclk;
   assign rst_n = s00_axi_aresetn;

   logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [LVL_W-1:0]        level;
   logic                    enable;
   logic                    irq_en;
   logic [15:0]             thresh;
   logic                    overflow;
   logic                    underflow;

   reg_addr_e                     wr_addr;
   reg_addr_e                     rd_addr;
   logic                          wr_en;
   logic                          rd_en;
   logic                          flush;
   logic                          full;
   logic                          empty;
   logic                          push;
   logic                          pop;
   logic                          drop;
   logic                          under;
   logic [31:0]                   sample_ext;
   logic [C_S00_AXI_DATA_WIDTH-1:0] rd_word;

   assign wr_addr = reg_addr_e'(s00_axi.awaddr[A_MSB:2]);
   assign rd_addr = reg_addr_e'(s00_axi.araddr[A_MSB:2]);
   assign wr_en   = s00_axi.awready & s00_axi.awvalid & s00_axi.wvalid;
   assign rd_en   = s00_axi.arready & s00_axi.arvalid;

   assign full  = (level == LVL_W'(FIFO_DEPTH));
   assign empty = (level == '0);
   // Flush acts on the write-handshake cycle itself and overrides any push or pop there.
   assign flush = wr_en & (wr_addr == REG_CTRL) & s00_axi.wstrb[0] & s00_axi.wdata[1];
   assign pop   = rd_en & (rd_addr == REG_DATA) & ~empty & ~flush;
   assign push  = sample_tvalid & enable & ~flush & (~full | pop);
   assign drop  = sample_tvalid & enable & ~flush & full & ~pop;
   assign under = rd_en & (rd_addr == REG_DATA) & empty;

   assign sample_ext = 32'($signed(mem[rd_ptr]));

   assign s00_axi.bresp = 2'b00;
   assign s00_axi.rresp = 2'b00;

   // NOTE: every default is assigned before the case so no path leaves rd_word unassigned (no latch).
   always_comb begin
      rd_word = '0;
      case (rd_addr)
         REG_CTRL: begin
            rd_word[0] = enable;
            rd_word[2] = irq_en;
         end
         REG_STATUS: rd_word = {12'd0, underflow, overflow, full, empty, 16'(level)};
         REG_DATA:   if (!empty) rd_word = sample_ext;
         REG_THRESH: rd_word[15:0] = thresh;
         default:    rd_word = '0;
      endcase
   end

   // NOTE: sequential state uses <= so every flop updates from the pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s00_axi.awready <= 1'b0;
         s00_axi.wready  <= 1'b0;
         s00_axi.bvalid  <= 1'b0;
         s00_axi.arready <= 1'b0;
         s00_axi.rvalid  <= 1'b0;
         s00_axi.rdata   <= '0;
      end else begin
         s00_axi.awready <= s00_axi.awvalid & s00_axi.wvalid & ~s00_axi.bvalid & ~s00_axi.awready;
         s00_axi.wready  <= s00_axi.awvalid & s00_axi.wvalid & ~s00_axi.bvalid & ~s00_axi.awready;
         if (wr_en)
            s00_axi.bvalid <= 1'b1;
         else if (s00_axi.bready)
            s00_axi.bvalid <= 1'b0;

         s00_axi.arready <= s00_axi.arvalid & ~s00_axi.rvalid & ~s00_axi.arready;
         if (rd_en) begin
            s00_axi.rvalid <= 1'b1;
            s00_axi.rdata  <= rd_word;
         end else if (s00_axi.rready) begin
            s00_axi.rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enable    <= 1'b0;
         irq_en    <= 1'b0;
         thresh    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en) begin
            case (wr_addr)
               REG_CTRL: if (s00_axi.wstrb[0]) begin
                  enable <= s00_axi.wdata[0];
                  irq_en <= s00_axi.wdata[2];
               end
               REG_STATUS: if (s00_axi.wstrb[2]) begin
                  if (s00_axi.wdata[18]) overflow  <= 1'b0;
                  if (s00_axi.wdata[19]) underflow <= 1'b0;
               end
               REG_THRESH: begin
                  if (s00_axi.wstrb[0]) thresh[7:0]  <= s00_axi.wdata[7:0];
                  if (s00_axi.wstrb[1]) thresh[15:8] <= s00_axi.wdata[15:8];
               end
               default: ;
            endcase
         end
         // A new event in the same cycle as a clear keeps the flag set.
         if (drop)  overflow  <= 1'b1;
         if (under) underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // NOTE: the sample storage has no reset; the pointers and level alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sample_tdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         irq <= 1'b0;
      else
         irq <= irq_en & (thresh != 16'd0) & (16'(level) >= thresh);
   end

   logic unused_bits;
   assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr, s00_axi.araddr,
                          s00_axi.wdata, s00_axi.wstrb};

endmodule

// File: tb/tb_decim_sample_readout.sv
// Scoreboard bench for decim_sample_readout: expected samples are queued when pushed
// and compared when popped through the DATA register.
module tb_decim_sample_readout;

   localparam int SW    = 24;
   localparam int DEPTH = 64;
   localparam logic [3:0] A_CTRL   = 4'h0;
   localparam logic [3:0] A_STATUS = 4'h4;
   localparam logic [3:0] A_DATA   = 4'h8;
   localparam logic [3:0] A_THRESH = 4'hC;

   logic          clk;
   logic          rst_n;
   logic [SW-1:0] sample_tdata;
   logic          sample_tvalid;
   logic          irq;

   decim_sample_readout_if bus ();

   decim_sample_readout #(
      .SAMPLE_WIDTH(SW),
      .FIFO_DEPTH(DEPTH),
      .C_S00_AXI_DATA_WIDTH(32),
      .C_S00_AXI_ADDR_WIDTH(4)
   ) dut (
      .s00_axi_aclk   (clk),
      .s00_axi_aresetn(rst_n),
      .sample_tdata   (sample_tdata),
      .sample_tvalid  (sample_tvalid),
      .irq            (irq),
      .s00_axi        (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] sb[$];
   bit          model_en;
   bit          model_ovf;
   bit          model_unf;

   function automatic logic [31:0] sext(input logic [SW-1:0] v);
      return {{(32-SW){v[SW-1]}}, v};
   endfunction

   function automatic logic [31:0] exp_status();
      int lvl;
      lvl = sb.size();
      return {12'd0, model_unf, model_ovf, (lvl == DEPTH), (lvl == 0), 16'(lvl)};
   endfunction

   task automatic push_sample(input logic [SW-1:0] v);
      @(negedge clk);
      sample_tdata  = v;
      sample_tvalid = 1'b1;
      if (model_en) begin
         if (sb.size() < DEPTH) sb.push_back(sext(v));
         else model_ovf = 1'b1;
      end
      @(negedge clk);
      sample_tvalid = 1'b0;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit with_sample, input logic [SW-1:0] smp);
      int n;
      @(negedge clk);
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      n = 0;
      while (bus.awready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (with_sample) begin
         sample_tdata  = smp;
         sample_tvalid = 1'b1;
      end
      @(negedge clk);
      bus.awvalid   = 1'b0;
      bus.wvalid    = 1'b0;
      sample_tvalid = 1'b0;
      bus.bready    = 1'b1;
      while (bus.bvalid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.bready = 1'b0;
      total_cnt++;
      if (n >= 20) $display("FAIL write_timeout addr=%h: waited %0d cycles, required < 20", addr, n);
      else pass_cnt++;
   endtask

   task automatic axi_read(input logic [3:0] addr, input bit with_sample, input logic [SW-1:0] smp,
                           output logic [31:0] data);
      int n;
      @(negedge clk);
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      n = 0;
      while (bus.arready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (with_sample) begin
         sample_tdata  = smp;
         sample_tvalid = 1'b1;
      end
      @(negedge clk);
      bus.arvalid   = 1'b0;
      sample_tvalid = 1'b0;
      bus.rready    = 1'b1;
      while (bus.rvalid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      data = bus.rdata;
      @(negedge clk);
      bus.rready = 1'b0;
      total_cnt++;
      if (n >= 20) $display("FAIL read_timeout addr=%h: waited %0d cycles, required < 20", addr, n);
      else pass_cnt++;
   endtask

   task automatic read_status(input string tag);
      logic [31:0] d;
      logic [31:0] exp;
      exp = exp_status();
      axi_read(A_STATUS, 1'b0, '0, d);
      total_cnt++;
      if (d !== exp) $display("FAIL %s status got=%h exp=%h", tag, d, exp);
      else pass_cnt++;
   endtask

   task automatic drain(input string tag, input int cnt);
      logic [31:0] d;
      logic [31:0] exp;
      for (int i = 0; i < cnt; i++) begin
         exp = (sb.size() != 0) ? sb.pop_front() : 32'd0;
         axi_read(A_DATA, 1'b0, '0, d);
         total_cnt++;
         if (d !== exp) $display("FAIL %s data[%0d] got=%h exp=%h", tag, i, d, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bresp, bus.rresp, irq} !== 10'd0 ||
          bus.rdata !== 32'd0)
         $display("FAIL reset_outputs got=%b rdata=%h exp=0", {bus.awready, bus.wready, bus.bvalid,
                  bus.arready, bus.rvalid, bus.bresp, bus.rresp, irq}, bus.rdata);
      else pass_cnt++;
      rst_n = 1'b1;
      read_status("reset");
      axi_read(A_CTRL, 1'b0, '0, d);
      total_cnt++;
      if (d !== 32'd0) $display("FAIL reset_ctrl got=%h exp=0", d);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, '0);
      model_en = 1'b1;
      for (int i = 1; i <= 4; i++) push_sample(SW'(i));
      read_status("basic_level4");
      drain("basic", 4);
      read_status("basic_empty");
   endtask

   task automatic test_sign_ext();
      push_sample(24'hFFFFFE);
      drain("sign_ext", 1);
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      logic [31:0] exp;
      for (int i = 0; i < DEPTH + 1; i++) push_sample(SW'(32'h100 + i));
      read_status("ovf_full");
      // Pop and push in the same cycle at full: level stays 64, no extra overflow.
      exp = sb.pop_front();
      sb.push_back(sext(24'h800123));
      axi_read(A_DATA, 1'b1, 24'h800123, d);
      total_cnt++;
      if (d !== exp) $display("FAIL full_pushpop data got=%h exp=%h", d, exp);
      else pass_cnt++;
      read_status("full_pushpop");
      drain("ovf", DEPTH);
      axi_write(A_STATUS, 32'h0004_0000, 4'b0100, 1'b0, '0);
      model_ovf = 1'b0;
      read_status("ovf_w1c");
   endtask

   task automatic test_underflow();
      drain("underflow", 1);
      model_unf = 1'b1;
      read_status("underflow_set");
      axi_write(A_STATUS, 32'h0008_0000, 4'b0000, 1'b0, '0);
      read_status("underflow_nostrb");
      axi_write(A_STATUS, 32'h0008_0000, 4'b0100, 1'b0, '0);
      model_unf = 1'b0;
      read_status("underflow_w1c");
   endtask

   task automatic test_irq();
      logic [31:0] d;
      axi_write(A_THRESH, 32'h0000_FF08, 4'b0001, 1'b0, '0);
      axi_read(A_THRESH, 1'b0, '0, d);
      total_cnt++;
      if (d !== 32'd8) $display("FAIL thresh_strb got=%h exp=%h", d, 32'd8);
      else pass_cnt++;
      axi_write(A_CTRL, 32'h5, 4'hF, 1'b0, '0);
      for (int i = 0; i < 8; i++) push_sample(SW'(32'h40 + i));
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL irq_latency got=%b exp=0", irq);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (irq !== 1'b1) $display("FAIL irq_assert got=%b exp=1", irq);
      else pass_cnt++;
      drain("irq", 1);
      @(negedge clk);
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL irq_deassert got=%b exp=0", irq);
      else pass_cnt++;
      drain("irq_rest", 7);
   endtask

   task automatic test_flush();
      logic [31:0] d;
      axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, '0);
      for (int i = 0; i < 10; i++) push_sample(SW'(32'h200 + i));
      read_status("flush_pre");
      axi_write(A_CTRL, 32'h3, 4'hF, 1'b1, 24'h00ABCD);
      sb.delete();
      read_status("flush_post");
      axi_read(A_CTRL, 1'b0, '0, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL flush_ctrl got=%h exp=%h", d, 32'h1);
      else pass_cnt++;
   endtask

   task automatic test_disabled();
      axi_write(A_CTRL, 32'h0, 4'hF, 1'b0, '0);
      model_en = 1'b0;
      push_sample(24'h123456);
      read_status("disabled");
   endtask

   task automatic test_reset_mid();
      axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, '0);
      model_en = 1'b1;
      for (int i = 0; i < 3; i++) push_sample(SW'(32'h300 + i));
      @(negedge clk);
      bus.araddr  = A_STATUS;
      bus.arvalid = 1'b1;
      repeat (2) @(negedge clk);
      bus.arvalid = 1'b0;
      total_cnt++;
      if (bus.rvalid !== 1'b1) $display("FAIL mid_rvalid_pending got=%b exp=1", bus.rvalid);
      else pass_cnt++;
      rst_n = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus.rvalid !== 1'b0) $display("FAIL mid_rvalid_drop got=%b exp=0", bus.rvalid);
      else pass_cnt++;
      rst_n = 1'b1;
      sb.delete();
      model_en  = 1'b0;
      model_ovf = 1'b0;
      model_unf = 1'b0;
      read_status("mid_reset");
   endtask

   initial begin
      rst_n         = 1'b0;
      sample_tdata  = '0;
      sample_tvalid = 1'b0;
      bus.awaddr    = '0;
      bus.awprot    = '0;
      bus.awvalid   = 1'b0;
      bus.wdata     = '0;
      bus.wstrb     = '0;
      bus.wvalid    = 1'b0;
      bus.bready    = 1'b0;
      bus.araddr    = '0;
      bus.arprot    = '0;
      bus.arvalid   = 1'b0;
      bus.rready    = 1'b0;
      model_en      = 1'b0;
      model_ovf     = 1'b0;
      model_unf     = 1'b0;

      test_reset();
      test_basic();
      test_sign_ext();
      test_overflow();
      test_underflow();
      test_irq();
      test_flush();
      test_disabled();
      test_reset_mid();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
